// File: rtl/or32_pkg.sv
// or32_pkg: shared data width and FIFO entry type for the OR-result buffer.
package or32_pkg;
  localparam int DW = 32;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          zero;
    logic          par;
  } entry_t;
endpackage

// File: rtl/or32_flag_gen.sv
// or32_flag_gen: combinational zero/parity flags for a 32-bit OR result.
// Parity is only produced when PARITY_EN is defined; otherwise o_par is 0.
module or32_flag_gen
  import or32_pkg::*;
(
  input  logic [DW-1:0] i_data,
  output logic          o_zero,
  output logic          o_par
);
  assign o_zero = ~|i_data;
`ifdef PARITY_EN
  assign o_par = ^i_data;
`else
  assign o_par = 1'b0;
`endif
endmodule

// File: rtl/or32_result_buffer.sv
// or32_result_buffer: valid/ready FIFO capturing bit32OR results with per-entry flags.
// Optional PARITY_EN builds per-entry parity storage; otherwise OUT_PAR is 0.
module or32_result_buffer
  import or32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CLR,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_ZERO,
  output logic          OUT_PAR,
  output logic [CW-1:0] COUNT
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [DW-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_zero;
  entry_t w_in, w_head;
  logic w_push, w_pop;
  or32_flag_gen u_flag (
    .i_data (IN_DATA),
    .o_zero (w_in.zero),
    .o_par  (w_in.par)
  );
  assign w_in.data = IN_DATA;
  assign IN_READY  = r_count != CW'(DEPTH);
  assign OUT_VALID = r_count != '0;
  assign w_push    = IN_VALID && IN_READY;
  assign w_pop     = OUT_VALID && OUT_READY;
  assign COUNT     = r_count;
`ifdef PARITY_EN
  logic [DEPTH-1:0] r_par;
  always_ff @(posedge CLK)
    if (w_push && !CLR) r_par[r_wr_ptr] <= w_in.par;
  assign w_head = '{data: r_data[r_rd_ptr], zero: r_zero[r_rd_ptr], par: r_par[r_rd_ptr]};
`else
  // Flag generator ties par to 0 in this build, so no storage is needed.
  assign w_head = '{data: r_data[r_rd_ptr], zero: r_zero[r_rd_ptr], par: w_in.par};
`endif
  assign OUT_DATA = w_head.data;
  assign OUT_ZERO = w_head.zero;
  assign OUT_PAR  = w_head.par;
  always_ff @(posedge CLK)
    if (w_push && !CLR) begin
      r_data[r_wr_ptr] <= w_in.data;
      r_zero[r_wr_ptr] <= w_in.zero;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: tb/tb_or32_result_buffer.sv
// tb_or32_result_buffer: directed-vector bench for or32_result_buffer.
// Expected parity follows PARITY_EN, matching the build of the design.
module tb_or32_result_buffer;
  import or32_pkg::*;
`ifdef PARITY_EN
  localparam logic PEN = 1'b1;
`else
  localparam logic PEN = 1'b0;
`endif
  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLR = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_ZERO;
  logic          OUT_PAR;
  logic [2:0]    COUNT;
  int n_vec = 0;
  int n_bad = 0;
  or32_result_buffer #(.DEPTH(4), .CW(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_ZERO(OUT_ZERO), .OUT_PAR(OUT_PAR), .COUNT(COUNT)
  );
  always #5 CLK = ~CLK;
  // Producer rule: data held while stalled.
  logic          p_stall = 1'b0;
  logic [DW-1:0] p_data = '0;
  always @(posedge CLK) begin
    if (p_stall && IN_VALID)
      assert (IN_DATA == p_data) else $error("FAIL input_stable got %h want %h", IN_DATA, p_data);
    p_stall <= IN_VALID && !IN_READY;
    p_data  <= IN_DATA;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic push(input logic [31:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    step();
    IN_VALID = 1'b0;
  endtask
  task automatic pop_check(input string tag, input logic [31:0] d, input logic z, input logic p);
    check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
    check({tag, "_data"}, OUT_DATA, d);
    check({tag, "_zero"}, 32'(OUT_ZERO), 32'(z));
    check({tag, "_par"}, 32'(OUT_PAR), 32'(p));
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
  endtask
  initial begin
    repeat (3) step();
    RST_N = 1'b1;
    step();
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    push(32'hA5A5A5A5 | 32'h5A5A5A5A);
    check("p1_valid", 32'(OUT_VALID), 32'd1);
    check("p1_data", OUT_DATA, 32'hFFFFFFFF);
    check("p1_zero", 32'(OUT_ZERO), 32'd0);
    check("p1_par", 32'(OUT_PAR), 32'd0);
    check("p1_count", 32'(COUNT), 32'd1);
    push(32'h00000000);
    push(32'h00000001);
    push(32'h97755779);
    check("full_count", 32'(COUNT), 32'd4);
    check("full_in_ready", 32'(IN_READY), 32'd0);
    check("full_head", OUT_DATA, 32'hFFFFFFFF);
    IN_VALID  = 1'b1;
    IN_DATA   = 32'hDEADBEEF;
    OUT_READY = 1'b1;
    step();
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    check("fullsim_count", 32'(COUNT), 32'd3);
    check("fullsim_in_ready", 32'(IN_READY), 32'd1);
    pop_check("d0", 32'h00000000, 1'b1, 1'b0);
    pop_check("d1", 32'h00000001, 1'b0, PEN);
    pop_check("d2", 32'h97755779, 1'b0, 1'b0);
    check("drain_count", 32'(COUNT), 32'd0);
    check("drain_valid", 32'(OUT_VALID), 32'd0);
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    IN_DATA   = 32'h01010101;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("stream_count", 32'(COUNT), 32'd1);
      check("stream_data", OUT_DATA, 32'h01010101 * k);
      IN_DATA = 32'h01010101 * (k + 1);
    end
    IN_VALID = 1'b0;
    step();
    OUT_READY = 1'b0;
    check("stream_end_count", 32'(COUNT), 32'd0);
    push(32'h11110000);
    push(32'h00002222);
    push(32'h33333333);
    check("preclr_count", 32'(COUNT), 32'd3);
    CLR       = 1'b1;
    IN_VALID  = 1'b1;
    IN_DATA   = 32'h44444444;
    OUT_READY = 1'b1;
    step();
    CLR       = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    check("clr_count", 32'(COUNT), 32'd0);
    check("clr_valid", 32'(OUT_VALID), 32'd0);
    check("clr_in_ready", 32'(IN_READY), 32'd1);
    push(32'h55550000);
    push(32'h00006666);
    check("prerst_count", 32'(COUNT), 32'd2);
    #2 RST_N = 1'b0;
    #1;
    check("arst_count", 32'(COUNT), 32'd0);
    check("arst_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    push(32'h80000000);
    check("postrst_count", 32'(COUNT), 32'd1);
    pop_check("postrst", 32'h80000000, 1'b0, PEN);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
